// File: rtl/ysyx_25020037_wbu_pkg.sv
// ysyx_25020037_wbu_pkg: shared encodings, bus width and holding-register
// layout for the write-back unit.
package ysyx_25020037_wbu_pkg;

    localparam int WU_TO_GU_BUS_WD = 142;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_CSR  = 2'b10,
        RES_PC4  = 2'b11
    } res_sel_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_type_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_REDIRECT = 2'd2,
        S_HALT     = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        gpr_wen;
        logic [1:0]  res_sel;
        logic [31:0] alu_res;
        logic [31:0] load_raw;
        logic [31:0] csr_rdata;
        logic [31:0] csr_wdata;
        logic [2:0]  ld_type;
        logic [1:0]  addr_lo;
        logic [5:0]  csr_wen;
        logic        ecall;
        logic        mret;
        logic [31:0] dnpc;
    } wb_hold_t;

endpackage

// File: rtl/ysyx_25020037_load_fmt.sv
// ysyx_25020037_load_fmt: aligns a raw load word by address and sign/zero extends.
module ysyx_25020037_load_fmt
    import ysyx_25020037_wbu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] res_o
);
    logic [31:0] sh;
    assign sh = raw_i >> {addr_lo_i, 3'b000};
    always_comb
        res_o = ld_type_i == LD_LB  ? {{24{sh[7]}}, sh[7:0]}   :
                ld_type_i == LD_LH  ? {{16{sh[15]}}, sh[15:0]} :
                ld_type_i == LD_LBU ? {24'd0, sh[7:0]}         :
                ld_type_i == LD_LHU ? {16'd0, sh[15:0]}        : raw_i;
endmodule

// File: rtl/ysyx_25020037_reg_en.sv
// ysyx_25020037_reg_en: enable register with asynchronous active-high reset.
module ysyx_25020037_reg_en #(
    parameter int          W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/ysyx_25020037_wbu.sv
// ysyx_25020037_wbu: write-back stage; commits one instruction to the register
// file, then offers the trap-adjusted next PC to the IFU.
module ysyx_25020037_wbu
    import ysyx_25020037_wbu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    input  logic [4:0]                 in_rd,
    input  logic                       in_gpr_wen,
    input  logic [1:0]                 in_res_sel,
    input  logic [31:0]                in_alu_res,
    input  logic [31:0]                in_load_raw,
    input  logic [31:0]                in_csr_rdata,
    input  logic [31:0]                in_csr_wdata,
    input  logic [2:0]                 in_ld_type,
    input  logic [1:0]                 in_addr_lo,
    input  logic [5:0]                 in_csr_wen,
    input  logic                       in_ecall,
    input  logic                       in_mret,
    input  logic [31:0]                in_dnpc,
    input  logic [31:0]                mtvec,
    input  logic [31:0]                mepc,
    output logic                       wbu_valid,
    output logic [WU_TO_GU_BUS_WD-1:0] wu_to_gu_bus,
    output logic                       npc_valid,
    input  logic                       npc_ready,
    output logic [31:0]                npc,
    output logic [31:0]                retire_cnt,
    output logic                       halt
);
    state_e      state_q, state_d;
    logic [1:0]  state_raw;
    wb_hold_t    hold_q, hold_d;
    logic [31:0] npc_q, npc_d, retire_cnt_q, retire_cnt_d, load_res, gpr_wdata;
    logic        halt_q, commit, is_ebreak;

    assign state_q   = state_e'(state_raw);
    assign commit    = state_q == S_COMMIT;
    assign is_ebreak = hold_q.inst == EBREAK;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        wbu_valid = 1'b0;
        npc_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                wbu_valid = 1'b1;
                state_d   = is_ebreak ? S_HALT : S_REDIRECT;
            end
            S_REDIRECT: begin
                npc_valid = 1'b1;
                if (npc_ready) state_d = S_IDLE;
            end
            default: ;
        endcase
    end

    assign hold_d = '{
        pc:        in_pc,
        inst:      in_inst,
        rd:        in_rd,
        gpr_wen:   in_gpr_wen,
        res_sel:   in_res_sel,
        alu_res:   in_alu_res,
        load_raw:  in_load_raw,
        csr_rdata: in_csr_rdata,
        csr_wdata: in_csr_wdata,
        ld_type:   in_ld_type,
        addr_lo:   in_addr_lo,
        csr_wen:   in_csr_wen,
        ecall:     in_ecall,
        mret:      in_mret,
        dnpc:      in_dnpc
    };

    // ecall outranks mret if upstream ever raises both
    assign npc_d        = hold_q.ecall ? mtvec : hold_q.mret ? mepc : hold_q.dnpc;
    assign retire_cnt_d = retire_cnt_q + 32'd1;

    ysyx_25020037_load_fmt u_load_fmt (
        .raw_i    (hold_q.load_raw),
        .addr_lo_i(hold_q.addr_lo),
        .ld_type_i(hold_q.ld_type),
        .res_o    (load_res)
    );

    assign gpr_wdata = hold_q.res_sel == RES_ALU  ? hold_q.alu_res   :
                       hold_q.res_sel == RES_LOAD ? load_res         :
                       hold_q.res_sel == RES_CSR  ? hold_q.csr_rdata : hold_q.pc + 32'd4;

    assign wu_to_gu_bus = commit ? {hold_q.pc, hold_q.inst, hold_q.rd, hold_q.csr_wen,
                                    hold_q.ecall, hold_q.mret, hold_q.csr_wdata,
                                    hold_q.gpr_wen, gpr_wdata} : '0;

    ysyx_25020037_reg_en #(.W(2), .RST_VAL(S_IDLE)) u_state (
        .clk(clk), .rst(rst), .en(1'b1), .d(state_d), .q(state_raw)
    );
    ysyx_25020037_reg_en #(.W($bits(wb_hold_t))) u_hold (
        .clk(clk), .rst(rst), .en(state_q == S_IDLE && in_valid), .d(hold_d), .q(hold_q)
    );
    ysyx_25020037_reg_en #(.W(32), .RST_VAL(RESET_PC)) u_npc (
        .clk(clk), .rst(rst), .en(commit), .d(npc_d), .q(npc_q)
    );
    ysyx_25020037_reg_en #(.W(32)) u_cnt (
        .clk(clk), .rst(rst), .en(commit), .d(retire_cnt_d), .q(retire_cnt_q)
    );
    ysyx_25020037_reg_en #(.W(1)) u_halt (
        .clk(clk), .rst(rst), .en(commit && is_ebreak), .d(1'b1), .q(halt_q)
    );

    assign npc        = npc_q;
    assign retire_cnt = retire_cnt_q;
    assign halt       = halt_q;
endmodule

// File: doc/ysyx_25020037_wbu.md
# ysyx_25020037_wbu

Write-back unit of the multi-cycle RV32E core. It sits between the LSU/EXU result stage and the register file.
- Accepts one finished instruction per handshake and formats load data.
- Selects the GPR write value and drives a one-cycle `wbu_valid` commit pulse with the packed write-back bus into the register file.
- Then hands the next PC (trap-adjusted) to the IFU over a valid/ready handshake.
- Also keeps a retired-instruction counter and a sticky halt on `ebreak`.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, value of `npc` after reset.

Ports (one clock; reset is asynchronous, active-high):
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous active-high reset.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  WBU can accept.
- `in_pc`, `in_inst`  in  32 each  PC and instruction word of the retiring instruction.
- `in_rd`  in  5  destination register.
- `in_gpr_wen`  in  1  instruction writes a GPR.
- `in_res_sel`  in  2  write-value source: 00 ALU, 01 load, 10 CSR old value, 11 pc+4.
- `in_alu_res`, `in_load_raw`, `in_csr_rdata`, `in_csr_wdata`  in  32 each  operand sources; `in_csr_wdata` is the new CSR value.
- `in_ld_type`  in  3  load funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- `in_addr_lo`  in  2  load address bits [1:0].
- `in_csr_wen`  in  6  one-hot CSR write enables {mtvec, mepc, mstatus, mcause, mvendorid, marchid}.
- `in_ecall`, `in_mret`  in  1 each  trap / trap-return flags.
- `in_dnpc`  in  32  sequential/branch next PC.
- `mtvec`, `mepc`  in  32 each  current CSR values from the register file.
- `wbu_valid`  out  1  commit pulse to the register file.
- `wu_to_gu_bus`  out  142  {pc, inst, rd, csr_wen[5:0], ecall, mret, csr_wdata, gpr_wen, gpr_wdata}, MSB first.
- `npc_valid`  out  1  next PC offered to the IFU.
- `npc_ready`  in  1  IFU accepts the next PC.
- `npc`  out  32  next PC.
- `retire_cnt`  out  32  retired instruction count.
- `halt`  out  1  sticky, set by `ebreak`.

## Operation
- FSM states: IDLE, COMMIT, REDIRECT, HALT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` it captures all `in_*` fields into holding registers and moves to COMMIT.
- COMMIT (exactly one cycle):
  - `wbu_valid`=1 and `wu_to_gu_bus` is driven from the held fields.
  - `retire_cnt` increments by 1; it wraps at 2^32.
  - `npc` is loaded as follows: `mtvec` if ecall; else `mepc` if mret; else held `in_dnpc`.
  - If the held inst equals 32'h0010_0073 (ebreak), `halt` is set and the FSM goes to HALT; otherwise it goes to REDIRECT.
- REDIRECT:
  - `npc_valid`=1 and `npc` is held stable.
  - On `npc_ready` the FSM returns to IDLE.
  - `in_ready`=0 throughout.
- HALT: terminal. `in_ready`=0 and `npc_valid`=0; only `rst` exits it.
- `gpr_wdata` selection per `in_res_sel`:
  - Load path: the raw word is shifted right by 8×`addr_lo`.
  - lb/lh sign-extend bits 7/15; lbu/lhu zero-extend.
  - lw ignores `addr_lo`.
- `gpr_wen` is forwarded as-is. Suppression of rd=0 writes is done in the register file, not here.
- An undefined `ld_type` yields the unshifted raw word.
- `wu_to_gu_bus` is all zero outside COMMIT.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1.
  - `wbu_valid`=0, `npc_valid`=0.
  - `npc`=`RESET_PC`, `retire_cnt`=0, `halt`=0.
  - Holding registers 0.
- Latency:
  - Accept edge to `wbu_valid`: 1 cycle.
  - Accept edge to `npc_valid`: 2 cycles.
  - Minimum 3 cycles per instruction with `npc_ready` tied high.
- `in_ready` is a registered function of state only. It has no combinational path from `in_valid`.
- The `npc` register changes only on the COMMIT edge. It is stable while `npc_valid`=1 and `npc_ready`=0, for an unbounded number of cycles.
- `mtvec`/`mepc` are sampled during COMMIT, before the register file applies this instruction's CSR writes, so the trap target is the pre-commit value.
- Simultaneous `in_ecall` and `in_mret` are illegal upstream. If it occurs anyway, ecall wins.
- `rst` asserted in any state, including mid-REDIRECT:
  - Outputs return to reset values immediately (asynchronously).
  - A pending `npc` is discarded and no commit is replayed.

## Structure
- Shared package/config header holds:
  - `res_sel` and `ld_type` encodings.
  - The EBREAK encoding.
  - `WU_TO_GU_BUS_WD`=142, with the field order above.
  - FSM state encodings.
- One natural sub-module: `ysyx_25020037_load_fmt`, the combinational shift/extend taking (raw, addr_lo, ld_type) and producing a 32-bit result.
- Sequential state uses the team's enable-register primitive with async reset.

## Test plan
- Reset release:
  - Stimulus: `in_valid`=1, ALU result 0x0000_002A, rd=5, `gpr_wen`=1, dnpc=0x8000_0004.
  - Required: `wbu_valid` pulses exactly 1 cycle with `gpr_wdata`=0x2A and rd=5; next cycle `npc_valid`=1, `npc`=0x8000_0004; `retire_cnt`=1.
- Load format:
  - lb with raw 0x1234_80FF, addr_lo=1 → `gpr_wdata`=0xFFFF_FF80.
  - lhu with addr_lo=2 → 0x0000_1234.
  - lw with addr_lo=3 → 0x1234_80FF.
- Trap redirect:
  - ecall with mtvec=0x8000_0100, dnpc=0x8000_0008 → `npc`=0x8000_0100, ecall bit set in the bus.
  - mret with mepc=0x8000_0020 → `npc`=0x8000_0020.
- Backpressure:
  - `npc_ready` held low for 5 cycles → `npc_valid` and `npc` stay constant, `in_ready`=0, no second `wbu_valid`.
  - Handshake completes on the 6th cycle, with `in_ready`=1 the following cycle.
- Halt:
  - inst 0x0010_0073 → one `wbu_valid` pulse, `halt`=1, never `npc_valid`.
  - Further `in_valid` is ignored until reset.
- Counter and reset:
  - Preload by 2^32−1 retires (force) and then one more → `retire_cnt`=0.
  - Assert `rst` during REDIRECT → `npc_valid`=0, `npc`=0x8000_0000, `retire_cnt`=0 in the same cycle.
